// File: rtl/scan_chain_loader_if.sv
// rtl/scan_chain_loader_if.sv - configuration controller / chain side bundle of the scan chain loader
interface scan_chain_loader_if #(
    parameter int WORD_W  = 32,
    parameter int COUNT_W = 16
);
    // load request
    logic               start;
    logic [COUNT_W-1:0] num_bits;
    // config word stream
    logic [WORD_W-1:0]  word_data;
    logic               word_valid;
    logic               word_ready;
    // programming interface towards the fabric
    logic               sc_clk;
    logic               sc_data;
    logic               sc_data_in;
    // status and readback
    logic               busy;
    logic               done;
    logic [WORD_W-1:0]  readback_data;
    logic               readback_valid;

    // controller / fabric side
    modport master (
        output start, num_bits, word_data, word_valid, sc_data_in,
        input  word_ready, sc_clk, sc_data, busy, done, readback_data, readback_valid
    );

    // loader side
    modport slave (
        input  start, num_bits, word_data, word_valid, sc_data_in,
        output word_ready, sc_clk, sc_data, busy, done, readback_data, readback_valid
    );
endinterface

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - serializes config words into the scan chain and captures the chain tail
module scan_chain_loader #(
    parameter int WORD_W  = 32,
    parameter int COUNT_W = 16,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    scan_chain_loader_if.slave bus
);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] bits_done_q, bits_done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [WORD_W-1:0]  rb_q, rb_d;
    logic [WORD_W-1:0]  rb_out_q, rb_out_d;
    logic               rb_valid_q, rb_valid_d;
    logic               sc_clk_q, sc_clk_d;
    logic               sc_data_q, sc_data_d;

    logic               phase_last;
    logic               idx_last;
    logic               last_bit;
    logic [IDX_W-1:0]   idx_next;
    logic [WORD_W-1:0]  rb_fill;

    // Bit index doubles as the readback position: words always start at
    // bit 0, so bits done mod WORD_W equals the index within the word.
    assign phase_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign idx_last   = (idx_q == IDX_W'(WORD_W - 1));
    assign last_bit   = ((bits_done_q + COUNT_W'(1)) == count_q);
    assign idx_next   = idx_q + IDX_W'(1);

    // Next-state, datapath and registered scan outputs
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bits_done_d = bits_done_q;
        idx_d       = idx_q;
        div_d       = div_q;
        word_d      = word_q;
        rb_d        = rb_q;
        rb_out_d    = rb_out_q;
        rb_valid_d  = 1'b0;
        sc_clk_d    = sc_clk_q;
        sc_data_d   = sc_data_q;
        rb_fill     = rb_q;
        rb_fill[idx_q] = bus.sc_data_in;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_bits != '0) begin
                        count_d     = bus.num_bits;
                        bits_done_d = '0;
                        state_d     = S_LOAD;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end

            S_LOAD: begin
                sc_clk_d = 1'b0;
                if (bus.word_valid) begin
                    word_d    = bus.word_data;
                    idx_d     = '0;
                    div_d     = '0;
                    sc_data_d = bus.word_data[0];
                    state_d   = S_LOW;
                end
            end

            S_LOW: begin
                if (phase_last) begin
                    // capture the tail before the rising edge shifts the chain
                    div_d    = '0;
                    sc_clk_d = 1'b1;
                    state_d  = S_HIGH;
                    if (idx_last) begin
                        rb_out_d   = rb_fill;
                        rb_valid_d = 1'b1;
                        rb_d       = '0;
                    end else begin
                        rb_d = rb_fill;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_HIGH: begin
                if (phase_last) begin
                    div_d       = '0;
                    sc_clk_d    = 1'b0;
                    bits_done_d = bits_done_q + COUNT_W'(1);
                    if (last_bit) begin
                        state_d = S_FINISH;
                        // a full final word was already flushed at its last sample
                        if (!idx_last) begin
                            rb_out_d   = rb_q;
                            rb_valid_d = 1'b1;
                            rb_d       = '0;
                        end
                    end else if (idx_last) begin
                        state_d = S_LOAD;
                    end else begin
                        idx_d     = idx_next;
                        sc_data_d = word_q[idx_next];
                        state_d   = S_LOW;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_FINISH: begin
                sc_clk_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            bits_done_q <= '0;
            idx_q       <= '0;
            div_q       <= '0;
            word_q      <= '0;
            rb_q        <= '0;
            rb_out_q    <= '0;
            rb_valid_q  <= 1'b0;
            sc_clk_q    <= 1'b0;
            sc_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bits_done_q <= bits_done_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            word_q      <= word_d;
            rb_q        <= rb_d;
            rb_out_q    <= rb_out_d;
            rb_valid_q  <= rb_valid_d;
            sc_clk_q    <= sc_clk_d;
            sc_data_q   <= sc_data_d;
        end
    end

    assign bus.word_ready     = (state_q == S_LOAD);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_FINISH);
    assign bus.sc_clk         = sc_clk_q;
    assign bus.sc_data        = sc_data_q;
    assign bus.readback_data  = rb_out_q;
    assign bus.readback_valid = rb_valid_q;
endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - directed self-checking bench for scan_chain_loader
module tb_scan_chain_loader;
    localparam int WW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    scan_chain_loader_if #(.WORD_W(WW), .COUNT_W(CW)) ia ();
    scan_chain_loader_if #(.WORD_W(WW), .COUNT_W(CW)) ib ();

    scan_chain_loader #(.WORD_W(WW), .COUNT_W(CW), .CLK_DIV(1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ia)
    );

    scan_chain_loader #(.WORD_W(WW), .COUNT_W(CW), .CLK_DIV(3)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ib)
    );

    // 17-element chain model on DUT A, shifted by sc_clk; tail feeds readback
    logic [16:0] chain_q = 17'h1B00F;
    always @(posedge ia.sc_clk) chain_q <= {ia.sc_data, chain_q[16:1]};
    assign ia.sc_data_in = chain_q[0];

    // DUT B: zero-length chain, tail equals head
    assign ib.sc_data_in = ib.sc_data;

    // DUT A observers
    int   rise_a = 0;
    logic rise_bits_a [0:255];
    always @(posedge ia.sc_clk) begin
        if (rise_a < 256) rise_bits_a[rise_a] = ia.sc_data;
        rise_a++;
    end

    int              done_a = 0;
    int              done_cyc_a = -1;
    int              rb_a = 0;
    logic [WW-1:0]   rb_data_a [0:15];
    int              rb_cyc_a [0:15];
    int              ready_a = 0;
    int              ready_hiclk_a = 0;
    always @(negedge clk) begin
        if (ia.done) begin
            done_a++;
            done_cyc_a = cyc;
        end
        if (ia.readback_valid) begin
            if (rb_a < 16) begin
                rb_data_a[rb_a] = ia.readback_data;
                rb_cyc_a[rb_a]  = cyc;
            end
            rb_a++;
        end
        if (ia.word_ready) begin
            ready_a++;
            if (ia.sc_clk) ready_hiclk_a++;
        end
    end

    // DUT B observers: phase lengths and data stability at rises
    logic          prev_clk_b = 1'b0;
    logic          prev_data_b = 1'b0;
    bit            in_low_b = 1'b0;
    int            hi_run_b = 0, lo_run_b = 0;
    int            hi_runs_b = 0, hi_bad_b = 0, lo_runs_b = 0, lo_bad_b = 0;
    int            unstable_b = 0, rise_b = 0;
    logic [31:0]   rise_vec_b = '0;
    int            done_b = 0, done_cyc_b = -1, rb_b = 0;
    logic [WW-1:0] rb_last_b = '0;
    always @(negedge clk) begin
        if (ib.sc_clk && !prev_clk_b) begin
            if (in_low_b) begin
                lo_runs_b++;
                if (lo_run_b != 3) lo_bad_b++;
            end
            if (ib.sc_data !== prev_data_b) unstable_b++;
            if (rise_b < 32) rise_vec_b[rise_b] = ib.sc_data;
            rise_b++;
            hi_run_b = 1;
        end else if (ib.sc_clk) begin
            hi_run_b++;
        end else if (prev_clk_b) begin
            hi_runs_b++;
            if (hi_run_b != 3) hi_bad_b++;
            in_low_b = 1'b1;
            lo_run_b = 1;
        end else begin
            lo_run_b++;
        end
        if (!ib.busy) in_low_b = 1'b0;
        if (ib.done) begin
            done_b++;
            done_cyc_b = cyc;
        end
        if (ib.readback_valid) begin
            rb_b++;
            rb_last_b = ib.readback_data;
        end
        prev_clk_b  = ib.sc_clk;
        prev_data_b = ib.sc_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input bit on_b, input int base, input string tag);
        int k;
        k = 0;
        while (((on_b ? done_b : done_a) == base) && k < 600) begin
            tick();
            k++;
        end
        check({tag, "_finished"}, 32'((on_b ? done_b : done_a) != base), 32'd1);
    endtask

    int          t;
    int          b_rise, b_done, b_rb, b_ready, b_hic;
    logic [31:0] vec;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ia.start = 1'b0; ia.num_bits = '0; ia.word_data = '0; ia.word_valid = 1'b0;
        ib.start = 1'b0; ib.num_bits = '0; ib.word_data = '0; ib.word_valid = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_a_outs", 32'({ia.sc_clk, ia.sc_data, ia.busy, ia.done, ia.word_ready, ia.readback_valid}), 32'd0);
        check("rst_a_rbdata", 32'(ia.readback_data), 32'd0);
        check("rst_b_outs", 32'({ib.sc_clk, ib.sc_data, ib.busy, ib.done, ib.word_ready, ib.readback_valid}), 32'd0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        tick();

        // 17-bit LUT load with loopback readback
        b_rise = rise_a; b_done = done_a; b_rb = rb_a; b_ready = ready_a;
        ia.start = 1'b1; ia.num_bits = 16'd17; ia.word_valid = 1'b1; ia.word_data = 16'hA5C3;
        t = cyc;
        tick();
        ia.start = 1'b0;
        check("t1_ready_at_t1", 32'(ia.word_ready), 32'd1);
        tick();
        ia.word_data = 16'h0001;
        wait_done(1'b0, b_done, "t1");
        check("t1_done_cycle", 32'(done_cyc_a - t), 32'd37);
        check("t1_rises", 32'(rise_a - b_rise), 32'd17);
        vec = '0;
        for (int i = 0; i < 17; i++) vec[i] = rise_bits_a[b_rise + i];
        check("t1_sc_data_at_rises", vec, 32'h0001_A5C3);
        check("t1_rb_pulses", 32'(rb_a - b_rb), 32'd2);
        check("t1_rb0_data", 32'(rb_data_a[b_rb]), 32'h0000_B00F);
        check("t1_rb0_cycle", 32'(rb_cyc_a[b_rb] - t), 32'd33);
        check("t1_rb1_data", 32'(rb_data_a[b_rb + 1]), 32'h0000_0001);
        check("t1_rb1_cycle", 32'(rb_cyc_a[b_rb + 1] - t), 32'd37);
        check("t1_ready_cycles", 32'(ready_a - b_ready), 32'd2);
        tick();
        check("t1_busy_after", 32'(ia.busy), 32'd0);

        // 40-bit load with a 5-cycle stall at the first word boundary, plus an ignored start
        b_rise = rise_a; b_done = done_a; b_rb = rb_a; b_ready = ready_a; b_hic = ready_hiclk_a;
        ia.start = 1'b1; ia.num_bits = 16'd40; ia.word_valid = 1'b1; ia.word_data = 16'h0F0F;
        t = cyc;
        tick();
        ia.start = 1'b0;
        tick();
        ia.word_valid = 1'b0;
        while (cyc < t + 10) tick();
        ia.start = 1'b1; ia.num_bits = 16'd0;
        tick();
        ia.start = 1'b0;
        while (cyc < t + 36) tick();
        check("t2_stall_ready", 32'(ia.word_ready), 32'd1);
        check("t2_stall_sc_clk", 32'(ia.sc_clk), 32'd0);
        while (cyc < t + 39) tick();
        ia.word_valid = 1'b1;
        wait_done(1'b0, b_done, "t2");
        check("t2_done_cycle", 32'(done_cyc_a - t), 32'd89);
        check("t2_rises", 32'(rise_a - b_rise), 32'd40);
        check("t2_ready_cycles", 32'(ready_a - b_ready), 32'd8);
        check("t2_ready_with_sc_clk", 32'(ready_hiclk_a - b_hic), 32'd0);
        check("t2_rb_pulses", 32'(rb_a - b_rb), 32'd3);
        repeat (3) tick();
        check("t2_single_done", 32'(done_a - b_done), 32'd1);

        // zero-length load
        b_rise = rise_a; b_done = done_a; b_ready = ready_a; b_rb = rb_a;
        ia.start = 1'b1; ia.num_bits = 16'd0;
        t = cyc;
        tick();
        ia.start = 1'b0;
        check("t3_done_at_t1", 32'({ia.done, ia.busy, ia.word_ready}), 32'b110);
        tick();
        check("t3_busy_after", 32'(ia.busy), 32'd0);
        check("t3_done_cycle", 32'(done_cyc_a - t), 32'd1);
        check("t3_no_activity", 32'({rise_a - b_rise, ready_a - b_ready, rb_a - b_rb}), 32'd0);

        // reset during HIGH of bit 9
        b_rise = rise_a; b_done = done_a; b_rb = rb_a;
        ia.start = 1'b1; ia.num_bits = 16'd17; ia.word_valid = 1'b1; ia.word_data = 16'hFFFF;
        t = cyc;
        tick();
        ia.start = 1'b0;
        while (cyc < t + 21) tick();
        check("t5_in_high_bit9", 32'({ia.sc_clk, ia.sc_data}), 32'b11);
        check("t5_rises_before", 32'(rise_a - b_rise), 32'd10);
        reset_a = 1'b1;
        tick();
        check("t5_after_reset", 32'({ia.sc_clk, ia.sc_data, ia.busy, ia.done}), 32'd0);
        reset_a = 1'b0;
        ia.word_valid = 1'b0;
        repeat (3) tick();
        check("t5_no_done_no_rb", 32'({done_a - b_done, rb_a - b_rb}), 32'd0);

        // full single-word load after the abort
        b_rise = rise_a; b_done = done_a; b_rb = rb_a;
        ia.start = 1'b1; ia.num_bits = 16'd16; ia.word_valid = 1'b1; ia.word_data = 16'h1234;
        t = cyc;
        tick();
        ia.start = 1'b0;
        wait_done(1'b0, b_done, "t5b");
        check("t5b_done_cycle", 32'(done_cyc_a - t), 32'd34);
        check("t5b_rises", 32'(rise_a - b_rise), 32'd16);
        vec = '0;
        for (int i = 0; i < 16; i++) vec[i] = rise_bits_a[b_rise + i];
        check("t5b_sc_data_at_rises", vec, 32'h0000_1234);
        tick();
        check("t5b_rb_pulses", 32'(rb_a - b_rb), 32'd1);

        // CLK_DIV=3 phase lengths on DUT B
        ib.start = 1'b1; ib.num_bits = 16'd5; ib.word_valid = 1'b1; ib.word_data = 16'h0015;
        t = cyc;
        tick();
        ib.start = 1'b0;
        wait_done(1'b1, 0, "t6");
        check("t6_done_cycle", 32'(done_cyc_b - t), 32'd32);
        check("t6_rises", 32'(rise_b), 32'd5);
        check("t6_sc_data_at_rises", rise_vec_b, 32'h0000_0015);
        check("t6_high_runs", 32'(hi_runs_b), 32'd5);
        check("t6_high_bad_len", 32'(hi_bad_b), 32'd0);
        check("t6_low_runs", 32'(lo_runs_b), 32'd4);
        check("t6_low_bad_len", 32'(lo_bad_b), 32'd0);
        check("t6_data_unstable", 32'(unstable_b), 32'd0);
        check("t6_rb_pulses", 32'(rb_b), 32'd1);
        check("t6_rb_data", 32'(rb_last_b), 32'h0000_0015);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish by 2000000");
        $fatal(1);
    end
endmodule
